// File: rtl/l2_request_arbiter_pkg.sv
// Shared L2 request definitions: core count, packet layout and arbiter FIFO depth.
package l2_request_arbiter_pkg;

   localparam int unsigned NUM_CORES         = 4;
   localparam int unsigned L2_ARB_FIFO_DEPTH = 4;

   localparam int unsigned CORE_ID_W   = 4;
   localparam int unsigned STRAND_ID_W = 2;
   localparam int unsigned ADDR_W      = 40;
   localparam int unsigned DATA_W      = 32;

   typedef enum logic [2:0] {
      L2REQ_LOAD     = 3'd0,
      L2REQ_STORE    = 3'd1,
      L2REQ_IFETCH   = 3'd2,
      L2REQ_ATOMIC   = 3'd3,
      L2REQ_PREFETCH = 3'd4
   } l2req_type_e;

   typedef struct packed {
      logic                   valid;
      l2req_type_e            req_type;
      logic [CORE_ID_W-1:0]   core_id;
      logic [STRAND_ID_W-1:0] strand_id;
      logic [ADDR_W-1:0]      address;
      logic [DATA_W-1:0]      data;
   } l2req_packet_t;

endpackage

// File: rtl/l2_request_fifo.sv
// Per-core request FIFO with registered full/empty flags derived from a registered count.
module l2_request_fifo
   import l2_request_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = L2_ARB_FIFO_DEPTH
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  l2req_packet_t wr_data,
   input  logic          rd_en,
   output l2req_packet_t head_c,
   output logic          full,
   output logic          empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   l2req_packet_t    mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt_c;
   logic             wr_ok_c;
   logic             rd_ok_c;

   // A full FIFO refuses writes even when it is being read in the same cycle.
   assign wr_ok_c     = wr_en && !full;
   assign rd_ok_c     = rd_en && !empty;
   assign count_nxt_c = count + CNT_W'(wr_ok_c) - CNT_W'(rd_ok_c);
   assign head_c      = mem[rd_ptr];

   // Storage array; payload only, so it carries no reset.
   always_ff @(posedge clk) begin
      if (wr_ok_c) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, occupancy and status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (wr_ok_c) begin
            wr_ptr <= PTR_W'(wr_ptr + 1'b1);
         end
         if (rd_ok_c) begin
            rd_ptr <= PTR_W'(rd_ptr + 1'b1);
         end
         count <= count_nxt_c;
         full  <= (count_nxt_c == CNT_W'(DEPTH));
         empty <= (count_nxt_c == '0);
      end
   end

endmodule

// File: rtl/l2_request_arbiter.sv
// Merges per-core L2 request streams into one registered L2 request port, round-robin.
module l2_request_arbiter
   import l2_request_arbiter_pkg::*;
#(
   parameter int unsigned NUM_PORTS  = NUM_CORES,
   parameter int unsigned FIFO_DEPTH = L2_ARB_FIFO_DEPTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  l2req_packet_t        core_l2req_packet [NUM_PORTS],
   output logic [NUM_PORTS-1:0] core_l2req_ready,
   output l2req_packet_t        l2req_packet,
   input  logic                 l2req_ready,
   output logic                 pc_event_l2_arb_conflict
);

   localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   l2req_packet_t        head_c [NUM_PORTS];
   logic [NUM_PORTS-1:0] full;
   logic [NUM_PORTS-1:0] empty;
   logic [NUM_PORTS-1:0] nonempty_c;
   logic [NUM_PORTS-1:0] deq_c;
   logic [PTR_W-1:0]     rr_ptr;
   logic [PTR_W-1:0]     grant_idx_c;
   logic [PTR_W-1:0]     rr_ptr_nxt_c;
   logic                 grant_found_c;
   logic                 multi_c;
   logic                 load_en_c;
   logic                 grant_c;

   // Output register may load whenever it is empty or being consumed.
   assign load_en_c  = !l2req_packet.valid || l2req_ready;
   assign nonempty_c = ~empty;
   assign grant_c    = load_en_c && grant_found_c;

   // Per-port request queues.
   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      assign deq_c[i]            = grant_c && (grant_idx_c == PTR_W'(i));
      assign core_l2req_ready[i] = !full[i];

      l2_request_fifo #(
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk     (clk),
         .reset   (reset),
         .wr_en   (core_l2req_packet[i].valid),
         .wr_data (core_l2req_packet[i]),
         .rd_en   (deq_c[i]),
         .head_c  (head_c[i]),
         .full    (full[i]),
         .empty   (empty[i])
      );
   end

   // Round-robin search: first non-empty port at or above rr_ptr, wrapping by compare.
   always_comb begin
      int unsigned idx;
      grant_found_c = 1'b0;
      grant_idx_c   = '0;
      idx           = 0;
      for (int unsigned off = 0; off < NUM_PORTS; off++) begin
         idx = 32'(rr_ptr) + off;
         if (idx >= NUM_PORTS) begin
            idx = idx - NUM_PORTS;
         end
         if (!grant_found_c && nonempty_c[PTR_W'(idx)]) begin
            grant_found_c = 1'b1;
            grant_idx_c   = PTR_W'(idx);
         end
      end
   end

   // Contention detect: two or more queues holding work.
   always_comb begin
      int unsigned cnt;
      cnt = 0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         cnt = cnt + 32'(nonempty_c[i]);
      end
      multi_c = (cnt >= 2);
   end

   // Pointer advances past the granted port, wrapping explicitly for non-power-of-two counts.
   assign rr_ptr_nxt_c = (grant_idx_c == PTR_W'(NUM_PORTS - 1)) ? '0
                                                                : PTR_W'(grant_idx_c + 1'b1);

   // Output stage, pointer and conflict event.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         l2req_packet             <= '0;
         rr_ptr                   <= '0;
         pc_event_l2_arb_conflict <= 1'b0;
      end else begin
         pc_event_l2_arb_conflict <= 1'b0;
         if (load_en_c) begin
            if (grant_found_c) begin
               l2req_packet             <= head_c[grant_idx_c];
               l2req_packet.valid       <= 1'b1;
               rr_ptr                   <= rr_ptr_nxt_c;
               pc_event_l2_arb_conflict <= multi_c;
            end else begin
               l2req_packet.valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter with per-port scoreboards checked at L2 transfers.
module tb_l2_request_arbiter;
   import l2_request_arbiter_pkg::*;

   localparam int unsigned NP = 4;

   logic          clk;
   logic          reset;
   l2req_packet_t req [NP];
   logic [NP-1:0] rdy;
   l2req_packet_t l2req_packet;
   logic          l2_rdy;
   logic          conflict;

   l2req_packet_t sb [NP][$];
   int            compared;
   int            mismatched;
   bit            rot_mode;
   int            rot_next;
   int            grants [NP];

   l2_request_arbiter #(
      .NUM_PORTS  (NP),
      .FIFO_DEPTH (4)
   ) dut (
      .clk                      (clk),
      .reset                    (reset),
      .core_l2req_packet        (req),
      .core_l2req_ready         (rdy),
      .l2req_packet             (l2req_packet),
      .l2req_ready              (l2_rdy),
      .pc_event_l2_arb_conflict (conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic l2req_packet_t mk(input int p, input logic [39:0] addr, input logic [31:0] data);
      l2req_packet_t pk;
      pk           = '0;
      pk.valid     = 1'b1;
      pk.req_type  = L2REQ_LOAD;
      pk.core_id   = 4'(p);
      pk.strand_id = 2'(p);
      pk.address   = addr;
      pk.data      = data;
      return pk;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request; it is accepted at the next edge iff ready is high now.
   task automatic offer(input int p, input l2req_packet_t pk, output bit acc);
      req[p] = pk;
      acc    = rdy[p];
      if (acc) sb[p].push_back(pk);
   endtask

   task automatic do_reset(input string tag);
      for (int p = 0; p < NP; p++) req[p] = '0;
      reset = 1'b1;
      #1;
      chk({tag, "_rst_valid"}, 128'(l2req_packet.valid), 128'(0));
      chk({tag, "_rst_ready"}, 128'(rdy), 128'(4'hf));
      chk({tag, "_rst_conflict"}, 128'(conflict), 128'(0));
      for (int p = 0; p < NP; p++) sb[p].delete();
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Scoreboard: a transfer happens at the next edge when valid and ready are both high now.
   always @(negedge clk) begin
      int p;
      if (!reset && l2req_packet.valid && l2_rdy) begin
         p = int'(l2req_packet.core_id);
         if (p >= NP || sb[p].size() == 0) begin
            chk("extra_pkt", 128'(l2req_packet), 128'(0));
         end else begin
            chk("sb_pkt", 128'(l2req_packet), 128'(sb[p].pop_front()));
            if (rot_mode) begin
               chk("rotation", 128'(p), 128'(rot_next));
               rot_next  = (rot_next + 1) % NP;
               grants[p] = grants[p] + 1;
            end
         end
      end
   end

   initial begin
      bit            acc;
      int            seq [NP];
      int            accepted;
      l2req_packet_t held;

      compared   = 0;
      mismatched = 0;
      rot_mode   = 1'b0;
      rot_next   = 0;
      l2_rdy     = 1'b1;
      reset      = 1'b0;
      for (int p = 0; p < NP; p++) begin
         req[p]    = '0;
         grants[p] = 0;
      end
      #2;
      do_reset("init");
      chk("init_pkt_zero", 128'(l2req_packet), 128'(0));

      // Single request from port 2
      offer(2, mk(2, 40'h1000, 32'hA5A5_0002), acc);
      chk("t1_ready2", 128'(acc), 128'(1));
      tick();
      req[2] = '0;
      chk("t1_not_yet", 128'(l2req_packet.valid), 128'(0));
      tick();
      chk("t1_valid", 128'(l2req_packet.valid), 128'(1));
      chk("t1_addr", 128'(l2req_packet.address), 128'(40'h1000));
      chk("t1_conflict", 128'(conflict), 128'(0));
      tick();
      chk("t1_drained", 128'(l2req_packet.valid), 128'(0));

      // All four ports at once
      do_reset("t2");
      for (int p = 0; p < NP; p++) offer(p, mk(p, 40'(32'h2000 + p), 32'(p)), acc);
      tick();
      for (int p = 0; p < NP; p++) req[p] = '0;
      for (int g = 0; g < NP; g++) begin
         tick();
         chk($sformatf("t2_order%0d", g), 128'(l2req_packet.core_id), 128'(g));
         chk($sformatf("t2_conflict%0d", g), 128'(conflict), 128'(g < 3 ? 1 : 0));
      end
      tick();
      chk("t2_idle", 128'(l2req_packet.valid), 128'(0));

      // Backpressure: port 1 streams into a stalled L2
      do_reset("t3");
      l2_rdy   = 1'b0;
      seq[1]   = 0;
      accepted = 0;
      for (int j = 0; j < 7; j++) begin
         offer(1, mk(1, {8'h01, 32'(seq[1])}, 32'(seq[1])), acc);
         if (acc) begin
            seq[1]++;
            accepted++;
         end
         tick();
      end
      chk("t3_accepted", 128'(accepted), 128'(5));
      chk("t3_ready_low", 128'(rdy[1]), 128'(0));
      chk("t3_head_addr", 128'(l2req_packet.address), 128'({8'h01, 32'd0}));
      held = l2req_packet;
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("t3_stable", 128'(l2req_packet), 128'(held));
      end
      req[1] = '0;
      l2_rdy = 1'b1;
      tick();
      chk("t3_ready_back", 128'(rdy[1]), 128'(1));
      for (int j = 0; j < 6; j++) tick();
      chk("t3_all_out", 128'(sb[1].size()), 128'(0));
      chk("t3_idle", 128'(l2req_packet.valid), 128'(0));

      // Saturation fairness over 100 grants
      do_reset("t4");
      for (int p = 0; p < NP; p++) begin
         seq[p]    = 0;
         grants[p] = 0;
      end
      for (int c = 0; c < 102; c++) begin
         for (int p = 0; p < NP; p++) begin
            offer(p, mk(p, {8'(p), 32'(seq[p])}, 32'(seq[p] * 7 + p)), acc);
            if (acc) seq[p]++;
         end
         if (c == 1) begin
            rot_mode = 1'b1;
            rot_next = 0;
         end
         tick();
      end
      rot_mode = 1'b0;
      for (int p = 0; p < NP; p++) req[p] = '0;
      for (int p = 0; p < NP; p++) chk($sformatf("t4_grants%0d", p), 128'(grants[p]), 128'(25));
      for (int j = 0; j < 30; j++) tick();
      chk("t4_idle", 128'(l2req_packet.valid), 128'(0));

      // Full FIFO while dequeuing: refused this cycle, accepted next
      do_reset("t5");
      l2_rdy = 1'b0;
      seq[0] = 0;
      for (int j = 0; j < 6; j++) begin
         offer(0, mk(0, {8'h50, 32'(seq[0])}, 32'(seq[0])), acc);
         if (acc) seq[0]++;
         tick();
      end
      l2_rdy = 1'b1;
      offer(0, mk(0, {8'h50, 32'(seq[0])}, 32'(seq[0])), acc);
      chk("t5_full_refuse", 128'(rdy[0]), 128'(0));
      if (acc) seq[0]++;
      tick();
      chk("t5_ready_next", 128'(rdy[0]), 128'(1));
      offer(0, mk(0, {8'h50, 32'(seq[0])}, 32'(seq[0])), acc);
      if (acc) seq[0]++;
      tick();
      req[0] = '0;
      chk("t5_seq", 128'(seq[0]), 128'(6));
      for (int j = 0; j < 10; j++) tick();
      chk("t5_all_out", 128'(sb[0].size()), 128'(0));

      // Reset with three queued and one held
      do_reset("t6pre");
      l2_rdy = 1'b0;
      seq[3] = 0;
      for (int j = 0; j < 4; j++) begin
         offer(3, mk(3, {8'h60, 32'(seq[3])}, 32'(seq[3])), acc);
         if (acc) seq[3]++;
         tick();
      end
      req[3] = '0;
      chk("t6_held", 128'(l2req_packet.valid), 128'(1));
      do_reset("t6");
      l2_rdy = 1'b1;
      for (int j = 0; j < 8; j++) begin
         tick();
         chk("t6_no_stale", 128'(l2req_packet.valid), 128'(0));
      end

      for (int p = 0; p < NP; p++) chk($sformatf("end_sb%0d", p), 128'(sb[p].size()), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
